// File: rtl/ifq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifq_pkg
//  Purpose  : Shared widths, reset PC and line type for the instruction
//             fetch queue and its line storage.
//  Revision : 1.0 - initial release
// ============================================================================
package ifq_pkg;

    localparam int INSTR_W        = 32;
    localparam int LINE_W         = 128;
    localparam int WORDS_PER_LINE = 4;

    localparam logic [31:0] DEFAULT_PC_RESET = 32'h0040_0000;

    typedef logic [LINE_W-1:0] line_t;

    // Word k of a line sits at bits [32k+31:32k]; word 0 is the lowest address.
    function automatic logic [INSTR_W-1:0] line_word(input line_t line, input logic [1:0] idx);
        logic [INSTR_W-1:0] w;
        case (idx)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            default: w = line[127:96];
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifq_line_ram.sv
`default_nettype none
// ============================================================================
//  Module   : ifq_line_ram
//  Purpose  : DEPTH x 128-bit line storage. Synchronous write, asynchronous
//             read, synchronous clear of every entry on reset.
//  Revision : 1.0 - initial release
// ============================================================================
module ifq_line_ram
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  line_t         wr_data,
    input  logic [AW-1:0] rd_addr,
    output line_t         rd_data
);

    line_t r_mem [DEPTH];

    // Clear all lines on reset so the head word reads as zero; otherwise write one line.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_queue
//  Purpose  : Requests 128-bit lines from the I-cache (one outstanding at a
//             time), buffers up to DEPTH lines and hands one instruction per
//             cycle with its PC to dispatch. A jump/branch redirect flushes
//             the queue and restarts fetch at the target; a response still in
//             flight at that moment is marked stale and discarded.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = DEFAULT_PC_RESET
) (
    input  logic               clk,
    input  logic               rst,
    output logic               icache_rd_en,
    output logic [31:0]        icache_addr,
    input  logic [LINE_W-1:0]  icache_dout,
    input  logic               icache_dout_val,
    input  logic               jmp_br_valid,
    input  logic [31:0]        jmp_br_addr,
    input  logic               dispatch_rd_en,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc_out,
    output logic               empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    localparam logic [CNT_W-1:0] c_full       = CNT_W'(DEPTH);
    localparam logic [31:0]      c_pc_start   = PC_RESET & 32'hFFFF_FFFC;
    localparam logic [1:0]       c_word_start = c_pc_start[3:2];

    // Queue pointers and occupancy (in lines).
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_line;
    logic [1:0]       r_rd_word;
    logic [CNT_W-1:0] r_count;

    // Only the line part of the fetch PC ever reaches the cache, so only
    // bits [31:4] are kept; "+16" on the PC is "+1" on this field.
    logic [27:0]      r_fetch_line;
    logic [31:0]      r_rd_pc;

    // One request in flight; stale marks it as belonging to a flushed stream.
    logic             r_pending;
    logic             r_stale;

    logic             w_pop;
    logic             w_pop_line;
    logic             w_push;
    line_t            w_head_line;
    logic [31:0]      w_redir_pc;

    assign w_redir_pc = jmp_br_addr & 32'hFFFF_FFFC;

    // Dispatch pop and line write strobes; a redirect suppresses the write.
    assign w_pop      = dispatch_rd_en & ~empty;
    assign w_pop_line = w_pop & (r_rd_word == 2'd3);
    assign w_push     = icache_dout_val & r_pending & ~r_stale & ~jmp_br_valid;

    // Cache request side: single outstanding request, never while flushing.
    assign icache_rd_en = ~rst & ~r_pending & ~r_stale & ~jmp_br_valid & (r_count < c_full);
    assign icache_addr  = {r_fetch_line, 4'b0000};

    ifq_line_ram #(
        .DEPTH   (DEPTH)
    ) u_line_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (icache_dout),
        .rd_addr (r_rd_line),
        .rd_data (w_head_line)
    );

    // Dispatch side: head word of the head line and its PC.
    assign empty  = (r_count == '0);
    assign instr  = line_word(w_head_line, r_rd_word);
    assign pc_out = r_rd_pc;

    // Queue state: reset acts as a redirect to PC_RESET; redirect beats fill and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_line    <= '0;
            r_rd_word    <= c_word_start;
            r_count      <= '0;
            r_fetch_line <= c_pc_start[31:4];
            r_rd_pc      <= c_pc_start;
            r_pending    <= 1'b0;
            r_stale      <= 1'b0;
        end else if (jmp_br_valid) begin
            r_wr_ptr     <= '0;
            r_rd_line    <= '0;
            r_rd_word    <= w_redir_pc[3:2];
            r_count      <= '0;
            r_fetch_line <= w_redir_pc[31:4];
            r_rd_pc      <= w_redir_pc;
            if (r_pending && icache_dout_val) begin
                // The outstanding response lands now and is simply dropped.
                r_pending <= 1'b0;
                r_stale   <= 1'b0;
            end else if (r_pending) begin
                // Still in flight: remember to discard it when it returns.
                r_stale   <= 1'b1;
            end
        end else begin
            if (icache_rd_en) begin
                r_pending <= 1'b1;
            end

            if (icache_dout_val && r_pending) begin
                r_pending <= 1'b0;
                r_stale   <= 1'b0;
                if (!r_stale) begin
                    r_wr_ptr     <= r_wr_ptr + AW'(1);
                    r_fetch_line <= r_fetch_line + 28'd1;
                end
            end

            if (w_pop) begin
                r_rd_pc   <= r_rd_pc + 32'd4;
                r_rd_word <= r_rd_word + 2'd1;
                if (w_pop_line) begin
                    r_rd_line <= r_rd_line + AW'(1);
                end
            end

            // Simultaneous line write and last-word pop leave the count unchanged.
            case ({w_push, w_pop_line})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_queue
//  Purpose  : Self-checking bench for instr_fetch_queue. A cache model
//             answers line requests with a fixed address->data mapping; the
//             expected dispatch stream is simply consecutive PCs from the last
//             reset/redirect target, each carrying mem_word(pc).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam logic [31:0] c_pc_reset = 32'h0040_0014;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         icache_rd_en;
    logic [31:0]  icache_addr;
    logic [127:0] icache_dout = '0;
    logic         icache_dout_val = 1'b0;
    logic         jmp_br_valid = 1'b0;
    logic [31:0]  jmp_br_addr = '0;
    logic         dispatch_rd_en = 1'b0;
    logic [31:0]  instr;
    logic [31:0]  pc_out;
    logic         empty;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        rq[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_pops = 0;
    int          cyc    = 0;
    int          lat    = 1;
    int          base;
    int          wi;
    logic        seen0, seen1;

    instr_fetch_queue #(
        .DEPTH           (4),
        .PC_RESET        (c_pc_reset)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .icache_rd_en    (icache_rd_en),
        .icache_addr     (icache_addr),
        .icache_dout     (icache_dout),
        .icache_dout_val (icache_dout_val),
        .jmp_br_valid    (jmp_br_valid),
        .jmp_br_addr     (jmp_br_addr),
        .dispatch_rd_en  (dispatch_rd_en),
        .instr           (instr),
        .pc_out          (pc_out),
        .empty           (empty)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory image seen through the cache: every word is a function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0003;
    endfunction

    function automatic logic [127:0] mk_line(input logic [31:0] a);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) begin
            l[32*k +: 32] = mem_word(a + 32'(4 * k));
        end
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // New instruction stream expected from this start PC onwards.
    task automatic exp_restart(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 600; i++) begin
            exp_q.push_back(start + 32'(4 * i));
        end
    endtask

    // I-cache model: records accepted requests and returns each line 'lat' cycles later.
    initial forever begin
        @(negedge clk);
        if (icache_rd_en) begin
            rq.push_back('{addr: icache_addr, due: cyc + 1 + lat});
        end
        @(posedge clk);
        #1;
        if (rq.size() > 0 && rq[0].due <= cyc + 1) begin
            icache_dout_val = 1'b1;
            icache_dout     = mk_line(rq[0].addr);
            void'(rq.pop_front());
        end else begin
            icache_dout_val = 1'b0;
            icache_dout     = '0;
        end
    end

    // Monitor: every instruction dispatch consumes is checked against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst && icache_rd_en) begin
            chk("req_align", {28'd0, icache_addr[3:0]}, 32'd0);
        end
        if (!rst && !jmp_br_valid && dispatch_rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_underflow: got pc %h, expected none", pc_out);
            end else begin
                exp_pc = exp_q.pop_front();
                chk("sb_pc", pc_out, exp_pc);
                chk("sb_instr", instr, mem_word(exp_pc));
            end
            n_pops++;
        end
    end

    initial begin
        exp_restart(c_pc_reset);

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_rd_en", 32'(icache_rd_en), 32'd0);
        chk("rst_addr", icache_addr, 32'h0040_0010);
        chk("rst_pc", pc_out, 32'h0040_0014);
        chk("rst_instr", instr, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // First request and fill latency with a 1-cycle cache.
        @(negedge clk);
        chk("first_req", 32'(icache_rd_en), 32'd1);
        chk("first_addr", icache_addr, 32'h0040_0010);
        @(negedge clk);
        chk("fill_empty", 32'(empty), 32'd1);
        @(negedge clk);
        chk("fill_ready", 32'(empty), 32'd0);
        chk("first_pc", pc_out, 32'h0040_0014);
        chk("first_instr", instr, mem_word(32'h0040_0014));

        // Fill to capacity with dispatch stalled.
        repeat (10) @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("full_stall", 32'(icache_rd_en), 32'd0);
            chk("full_not_empty", 32'(empty), 32'd0);
        end

        // Pop words 1..3 of the first line; only the word-3 pop frees a slot.
        lat = 3;
        @(posedge clk);
        #1 dispatch_rd_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_during_pops", 32'(icache_rd_en), 32'd0);
            @(posedge clk);
            #1;
        end
        dispatch_rd_en = 1'b0;
        @(negedge clk);
        chk("resume_req", 32'(icache_rd_en), 32'd1);
        chk("resume_addr", icache_addr, 32'h0040_0050);

        // Redirect with a request outstanding (3-cycle cache).
        @(posedge clk);
        #1;
        jmp_br_valid = 1'b1;
        jmp_br_addr  = 32'h0040_0108;
        exp_restart(32'h0040_0108);
        @(negedge clk);
        chk("redir_no_req", 32'(icache_rd_en), 32'd0);
        @(posedge clk);
        #1 jmp_br_valid = 1'b0;
        @(negedge clk);
        chk("redir_empty", 32'(empty), 32'd1);
        chk("stale_wait1", 32'(icache_rd_en), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stale_wait2", 32'(icache_rd_en), 32'd0);
        chk("stale_still_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("redir_req", 32'(icache_rd_en), 32'd1);
        chk("redir_addr", icache_addr, 32'h0040_0100);
        wi = 0;
        while (empty && wi < 50) begin
            @(negedge clk);
            wi++;
        end
        chk("redir_fill_timeout", 32'(empty), 32'd0);
        chk("redir_pc", pc_out, 32'h0040_0108);
        chk("redir_instr", instr, mem_word(32'h0040_0108));

        // Redirect in the same cycle as a response and a dispatch request.
        lat = 1;
        wi = 0;
        do begin
            @(posedge clk);
            #2;
            wi++;
        end while (!icache_dout_val && wi < 50);
        chk("resp_wait_timeout", 32'(icache_dout_val), 32'd1);
        jmp_br_valid   = 1'b1;
        jmp_br_addr    = 32'h0040_0200;
        dispatch_rd_en = 1'b1;
        lat            = 3;
        exp_restart(32'h0040_0200);
        @(posedge clk);
        #1;
        jmp_br_valid   = 1'b0;
        dispatch_rd_en = 1'b0;
        @(negedge clk);
        chk("coll_empty", 32'(empty), 32'd1);
        chk("coll_req", 32'(icache_rd_en), 32'd1);
        chk("coll_addr", icache_addr, 32'h0040_0200);

        // Continuous dispatch, 3-cycle cache, 8+ lines with pointer wrap.
        @(posedge clk);
        #1 dispatch_rd_en = 1'b1;
        base  = n_pops;
        seen0 = 1'b0;
        seen1 = 1'b0;
        for (int i = 0; i < 400 && (n_pops - base) < 34; i++) begin
            @(negedge clk);
            if (empty) seen1 = 1'b1;
            else       seen0 = 1'b1;
        end
        chk("cont_pops", 32'((n_pops - base) >= 34), 32'd1);
        chk("cont_empty_toggles", 32'(seen0 && seen1), 32'd1);

        // Stream across the top of the address space.
        @(posedge clk);
        #1;
        jmp_br_valid = 1'b1;
        jmp_br_addr  = 32'hFFFF_FFE6;
        exp_restart(32'hFFFF_FFE4);
        @(posedge clk);
        #1 jmp_br_valid = 1'b0;
        repeat (60) @(posedge clk);

        // Randomized traffic: latency, dispatch and redirects.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            lat            = int'($urandom_range(1, 3));
            dispatch_rd_en = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) begin
                jmp_br_valid = 1'b1;
                jmp_br_addr  = $urandom;
                exp_restart(jmp_br_addr & 32'hFFFF_FFFC);
            end else begin
                jmp_br_valid = 1'b0;
            end
        end

        // Reset pulsed mid-fill with a response still in flight.
        @(posedge clk);
        #1;
        lat            = 3;
        dispatch_rd_en = 1'b0;
        jmp_br_valid   = 1'b1;
        jmp_br_addr    = 32'h0040_0300;
        exp_restart(32'h0040_0300);
        @(posedge clk);
        #1 jmp_br_valid = 1'b0;
        wi = 0;
        while (empty && wi < 50) begin
            @(negedge clk);
            wi++;
        end
        chk("midfill_timeout", 32'(empty), 32'd0);
        wi = 0;
        do begin
            @(negedge clk);
            wi++;
        end while (!icache_rd_en && wi < 50);
        chk("midfill_req_timeout", 32'(icache_rd_en), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_restart(c_pc_reset);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_rd_en", 32'(icache_rd_en), 32'd0);
        chk("mid_rst_addr", icache_addr, 32'h0040_0010);
        chk("mid_rst_pc", pc_out, 32'h0040_0014);
        chk("mid_rst_instr", instr, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req", 32'(icache_rd_en), 32'd1);
        chk("post_rst_addr", icache_addr, 32'h0040_0010);
        @(posedge clk);
        #1 dispatch_rd_en = 1'b1;
        base = n_pops;
        for (int i = 0; i < 60 && (n_pops - base) < 8; i++) begin
            @(negedge clk);
        end
        chk("post_rst_pops", 32'((n_pops - base) >= 8), 32'd1);

        @(posedge clk);
        #1 dispatch_rd_en = 1'b0;
        repeat (5) @(posedge clk);
        chk("total_pops", 32'(n_pops > 200), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch queue (IFQ) for the RISC-V single-issue Tomasulo core. It requests 128-bit lines (four instructions) from the instruction cache and buffers up to DEPTH lines. It presents one instruction per cycle, with its PC, to the dispatch unit, and flushes and refetches on a jump/branch redirect from the execution side.

## Interface
- `DEPTH`, default 4: queue capacity in lines; power of two, minimum 2.
- `PC_RESET`, default 32'h0040_0000: PC of the first instruction after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `icache_rd_en` out 1: line request; accepted at the clock edge where it is high.
- `icache_addr` out 32: line-aligned fetch address, bits [3:0] always 0.
- `icache_dout` in 128: returned line; word k is bits [32k+31:32k], with word 0 at the lowest address.
- `icache_dout_val` in 1: `icache_dout` is valid this cycle; arrives one or more cycles after the request.
- `jmp_br_valid` in 1: redirect request.
- `jmp_br_addr` in 32: redirect target; bits [1:0] are ignored.
- `dispatch_rd_en` in 1: dispatch consumes the head instruction this edge.
- `instr` out 32: head instruction.
- `pc_out` out 32: PC of `instr`.
- `empty` out 1: no valid head instruction.

## Operation
- State:
  - line storage DEPTH×128
  - `wr_ptr` and `rd_line` (log2 DEPTH bits each, wrapping)
  - `rd_word` (2 bits)
  - `count` (0..DEPTH)
  - `fetch_pc`, `rd_pc`
  - `pending` and `stale` flags
- Request rule: `icache_rd_en` = !rst & !pending & !stale & !jmp_br_valid & (count < DEPTH).
  - `icache_addr` = {fetch_pc[31:4], 4'b0}.
  - At most one request may be outstanding.
- Request acceptance: when `icache_rd_en` is high at an edge, `pending` is set.
- Response with `icache_dout_val` high and `stale` = 0:
  - write the line at `wr_ptr`;
  - increment `wr_ptr` and `count`;
  - `fetch_pc` += 16;
  - clear `pending`.
- Response with `stale` = 1: discard the data and clear both `stale` and `pending`.
- A response that arrives while `pending` = 0 is ignored.
- Read:
  - `empty` = (count == 0).
  - `instr` = storage[rd_line][rd_word].
  - On `dispatch_rd_en` & !empty: `rd_pc` += 4 and `rd_word` += 1.
  - When `rd_word` wraps from 3 to 0, `rd_line` increments and `count` decrements.
  - `dispatch_rd_en` while empty is ignored.
- Same-cycle line write and last-word pop are both performed; `count` is unchanged. At full, a pop of word 3 frees one slot, and the request may be raised the following cycle.
- Redirect (`jmp_br_valid` high) has priority over everything else in that cycle:
  - `count`, `wr_ptr` and `rd_line` are set to 0;
  - `fetch_pc` = `jmp_br_addr` & ~3; `rd_pc` = `jmp_br_addr` & ~3;
  - `rd_word` = `jmp_br_addr`[3:2];
  - if `pending` is set, or a response arrives in the same cycle, `stale` is set (unless that response closes the pending request);
  - a same-cycle `dispatch_rd_en` is dropped.
- Start offset: `rd_word` is loaded from the start PC, so earlier words of the first line are skipped. Reset behaves as a redirect to `PC_RESET`.
- Arithmetic: all PC increments are mod 2^32; pointers wrap mod DEPTH.

## Timing
- Reset values:
  - `empty` = 1, `icache_rd_en` = 0, `icache_addr` = PC_RESET & ~32'hF;
  - `pc_out` = PC_RESET, `instr` = 0 (storage cleared on reset);
  - `pending` = `stale` = 0, `count` = 0.
- First request: `icache_rd_en` rises in the first cycle with `rst` low.
- Fill latency: with a 1-cycle cache, the request is at edge N, data arrives at edge N+1, and `empty` falls after edge N+1. The first instruction is available 2 cycles after the request.
- Sustained throughput: one line per 2 cycles under the single-outstanding rule. This covers the dispatch rate of one word per cycle after the initial fill.
- Redirect: at edge R the queue flushes. `empty` = 1 in cycle R+1. The new request is issued in cycle R+1 if no request is outstanding, otherwise one cycle after the stale response returns.
- Reset asserted mid-operation: all state returns to reset values at the next edge, and an in-flight response is ignored.

## Structure
- Shared package `ifq_pkg` holds:
  - `INSTR_W` = 32, `LINE_W` = 128, `WORDS_PER_LINE` = 4;
  - the default `PC_RESET`;
  - a `line_t` typedef.
- One sub-module: `ifq_line_ram`, DEPTH×128 storage with a synchronous write port, an asynchronous read port, and synchronous clear.

## Test plan
- Reset, PC_RESET = 0x0040_0014, cache returning line 0x0040_0010 after 1 cycle -> `icache_addr` = 0x0040_0010; the first `pc_out` is 0x0040_0014 with `instr` = word 1; the next pops give 0x0040_0018 and 0x0040_001C, then 0x0040_0020 from the next line.
- Dispatch stalled until 4 lines are loaded -> `icache_rd_en` stays low at count = 4. One word-3 pop -> the request resumes the next cycle, with `icache_addr` = last address + 16.
- Redirect to 0x0040_0108 with a request outstanding -> `empty` = 1 next cycle; the stale line is discarded and never dispatched; the next request is 0x0040_0100; the first `pc_out` is 0x0040_0108.
- Redirect in the same cycle as `icache_dout_val` and `dispatch_rd_en` -> the line is not written, there is no pop, and the queue is empty afterwards.
- Continuous dispatch with 3-cycle cache latency -> `empty` toggles; PCs are strictly sequential +4 with no duplicates or skips across 8 lines, including pointer wrap.
- `rst` pulsed mid-fill -> outputs return to their reset values next cycle, and the late `icache_dout_val` is ignored.
